conv_8b_32b: RTL and testbench

- Byte-to-word packer on the receive side of the 8b link, directly downstream of the 32b->8b serializer.
- Samples one 8-bit byte per clk_4f cycle while valid_in is high and assembles four consecutive bytes MSB-first into a 32-bit word.
- Presents each word on data_out held for one word period (4 clk_4f cycles), so a clk_f-rate consumer can sample it.
- Flags and discards partial words broken by a valid gap.

---
 rtl/conv_8b_32b.sv | 102 ++++++++++
 tb/tb_conv_8b_32b.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_8b_32b.sv
// ---------------------------------------------------------------------------
// conv_8b_32b
//   Byte-to-word packer on the receive side of the 8b link. Bytes arriving
//   one per clk_4f cycle are assembled MSB-first into NBYTES-byte words.
//   Each finished word is held on data_out with valid_out high for HOLD
//   clk_4f cycles, so a consumer running at clk_f can sample it.
//   A valid gap in the middle of a word throws the partial word away and
//   pulses align_err for one cycle.
//
// Qualifier semantics (no backpressure anywhere):
//   valid_in  - data_in is a real byte on every rising clk_4f edge where
//               valid_in is 1. There is no ready; every such byte is taken.
//   valid_out - data_out carries a finished word while valid_out is 1. The
//               consumer must sample it inside the hold window. data_out
//               keeps its last value after valid_out drops.
//
// Ports:
//   clk_4f    in   fast clock, all logic on its rising edge
//   reset     in   synchronous, active-high
//   data_in   in   BYTE_W-bit byte; the first byte of a word lands in the MSBs
//   valid_in  in   data_in qualifier
//   data_out  out  assembled word (registered)
//   valid_out out  data_out qualifier (registered)
//   align_err out  one-cycle pulse when a partial word is discarded
// ---------------------------------------------------------------------------
module conv_8b_32b #(
  parameter int BYTE_W = 8,
  parameter int NBYTES = 4,
  parameter int HOLD   = 4
) (
  input  logic                     clk_4f,
  input  logic                     reset,
  input  logic [BYTE_W-1:0]        data_in,
  input  logic                     valid_in,
  output logic [BYTE_W*NBYTES-1:0] data_out,
  output logic                     valid_out,
  output logic                     align_err
);

  localparam int W      = BYTE_W * NBYTES;
  // Only the first NBYTES-1 bytes need storing; the last one comes straight
  // from data_in on the completion edge.
  localparam int SH_W   = W - BYTE_W;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NBYTES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD - 1);

  logic [SH_W-1:0]   shreg;
  logic [CNT_W-1:0]  cnt;
  logic [HOLD_W-1:0] hold_cnt;

  logic word_done;
  logic gap_abort;

  // The byte taken this edge is the last one of the word.
  assign word_done = valid_in && (cnt == LAST_BYTE);
  // A missing byte after the word has started: the partial word is lost.
  assign gap_abort = !valid_in && (cnt != '0);

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      shreg     <= '0;
      cnt       <= '0;
      hold_cnt  <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      align_err <= 1'b0;
    end else begin
      // Byte assembly. The cast keeps the low SH_W bits, i.e. drops the
      // oldest byte as the new one shifts in.
      if (valid_in) begin
        shreg <= SH_W'({shreg, data_in});
        if (word_done) begin
          data_out <= {shreg, data_in};
          cnt      <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else if (gap_abort) begin
        cnt <= '0;
      end

      align_err <= gap_abort;

      // Hold window. A new completion wins over expiry so back-to-back
      // words keep valid_out high without a dip.
      if (word_done) begin
        valid_out <= 1'b1;
        hold_cnt  <= HOLD_LOAD;
      end else if (valid_out) begin
        if (hold_cnt == '0) begin
          valid_out <= 1'b0;
        end else begin
          hold_cnt <= hold_cnt - HOLD_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_8b_32b.sv
// ---------------------------------------------------------------------------
// tb_conv_8b_32b
//   Bench for conv_8b_32b. Expected words go into exp_q when the test drives
//   them; the monitor pops and compares each time the DUT presents a new word
//   (valid_out rising, or data_out changing while valid_out stays high).
//   Each test task also checks valid_out / align_err / data_out timing inline.
// ---------------------------------------------------------------------------
module tb_conv_8b_32b;

  logic        clk_4f;
  logic        reset;
  logic [7:0]  data_in;
  logic        valid_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        align_err;

  int n_tests;
  int n_fail;

  logic [31:0] exp_q[$];
  logic        prev_v;
  logic [31:0] prev_d;

  conv_8b_32b #(
    .BYTE_W(8),
    .NBYTES(4),
    .HOLD  (4)
  ) dut (
    .clk_4f   (clk_4f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .align_err(align_err)
  );

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  initial begin
    clk_4f = 1'b0;
    forever #5 clk_4f = ~clk_4f;
  end

  // -------------------------------------------------------------------------
  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  // -------------------------------------------------------------------------
  initial begin
    prev_v = 1'b0;
    prev_d = '0;
  end

  always @(negedge clk_4f) begin
    if (reset === 1'b1) begin
      prev_v = 1'b0;
      prev_d = '0;
    end else begin
      if (valid_out === 1'b1 && (prev_v !== 1'b1 || data_out !== prev_d)) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_word: got %08h, want no word", data_out);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (data_out !== e) begin
            n_fail++;
            $display("FAIL sb_word: got %08h, want %08h", data_out, e);
          end
        end
      end
      prev_v = valid_out;
      prev_d = data_out;
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  // Present one input for one edge; returns 1 time unit after that edge.
  task automatic cycle(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in  = d;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  // -------------------------------------------------------------------------
  // Tests
  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    n_tests++;
    if (data_out !== 32'h0 || valid_out !== 1'b0 || align_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got do=%08h vo=%b ae=%b, want 00000000 0 0",
               data_out, valid_out, align_err);
    end
  endtask

  task automatic test_single();
    logic [7:0] b [4];
    b = '{8'hFF, 8'hFB, 8'hBF, 8'hFF};
    exp_q.push_back(32'hFFFBBFFF);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, b[i]);
      n_tests++;
      if (valid_out !== (i == 3) || align_err !== 1'b0) begin
        n_fail++;
        $display("FAIL single_byte%0d: got vo=%b ae=%b, want vo=%b ae=0",
                 i, valid_out, align_err, (i == 3));
      end
    end
    n_tests++;
    if (data_out !== 32'hFFFBBFFF) begin
      n_fail++;
      $display("FAIL single_latency: got %08h, want FFFBBFFF", data_out);
    end
    // valid_out high for 4 cycles in total, low after the 4th idle edge.
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b0, 8'h00);
      n_tests++;
      if (valid_out !== (k < 4)) begin
        n_fail++;
        $display("FAIL single_hold%0d: got vo=%b, want %b", k, valid_out, (k < 4));
      end
    end
    n_tests++;
    if (data_out !== 32'hFFFBBFFF) begin
      n_fail++;
      $display("FAIL single_data_kept: got %08h, want FFFBBFFF", data_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [8];
    b = '{8'hFF, 8'hFB, 8'hBF, 8'hFF, 8'hDD, 8'hDD, 8'hDD, 8'hDD};
    exp_q.push_back(32'hFFFBBFFF);
    exp_q.push_back(32'hDDDDDDDD);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, b[i]);
      n_tests++;
      if (valid_out !== (i >= 3) || align_err !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_cyc%0d: got vo=%b ae=%b, want vo=%b ae=0",
                 i, valid_out, align_err, (i >= 3));
      end
      if (i == 6) begin
        n_tests++;
        if (data_out !== 32'hFFFBBFFF) begin
          n_fail++;
          $display("FAIL b2b_first_word: got %08h, want FFFBBFFF", data_out);
        end
      end
    end
    n_tests++;
    if (data_out !== 32'hDDDDDDDD) begin
      n_fail++;
      $display("FAIL b2b_second_word: got %08h, want DDDDDDDD", data_out);
    end
    idle(4);
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got vo=%b, want 0", valid_out);
    end
  endtask

  task automatic test_aligned_gap();
    logic [7:0] b [4];
    b = '{8'hDD, 8'h00, 8'h00, 8'h03};
    exp_q.push_back(32'hDDDDDDDD);
    exp_q.push_back(32'hDD000003);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hDD);
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b0, 8'hAA);
      n_tests++;
      if (align_err !== 1'b0 || valid_out !== (k < 4) || data_out !== 32'hDDDDDDDD) begin
        n_fail++;
        $display("FAIL agap_gap%0d: got ae=%b vo=%b do=%08h, want 0 %b DDDDDDDD",
                 k, align_err, valid_out, data_out, (k < 4));
      end
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, b[i]);
      n_tests++;
      if (align_err !== 1'b0 || valid_out !== (i == 3)) begin
        n_fail++;
        $display("FAIL agap_byte%0d: got ae=%b vo=%b, want 0 %b",
                 i, align_err, valid_out, (i == 3));
      end
    end
    n_tests++;
    if (data_out !== 32'hDD000003) begin
      n_fail++;
      $display("FAIL agap_word: got %08h, want DD000003", data_out);
    end
    idle(4);
  endtask

  task automatic test_mid_gap();
    logic       v  [7];
    logic [7:0] b  [7];
    logic       ae [7];
    v  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    b  = '{8'h12, 8'h34, 8'h00, 8'h56, 8'h78, 8'h9A, 8'hBC};
    ae = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_q.push_back(32'h56789ABC);
    for (int i = 0; i < 7; i++) begin
      cycle(v[i], b[i]);
      n_tests++;
      if (align_err !== ae[i] || valid_out !== (i == 6)) begin
        n_fail++;
        $display("FAIL mgap_cyc%0d: got ae=%b vo=%b, want %b %b",
                 i, align_err, valid_out, ae[i], (i == 6));
      end
    end
    n_tests++;
    if (data_out !== 32'h56789ABC) begin
      n_fail++;
      $display("FAIL mgap_word: got %08h, want 56789ABC", data_out);
    end
    idle(4);
  endtask

  task automatic test_reset_mid();
    logic [7:0] b [4];
    b = '{8'h33, 8'h44, 8'h55, 8'h66};
    cycle(1'b1, 8'h11);
    cycle(1'b1, 8'h22);
    // Gap coincides with reset: reset must win, so no align_err.
    reset = 1'b1;
    cycle(1'b0, 8'h00);
    reset = 1'b0;
    n_tests++;
    if (data_out !== 32'h0 || valid_out !== 1'b0 || align_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_reset: got do=%08h vo=%b ae=%b, want 00000000 0 0",
               data_out, valid_out, align_err);
    end
    exp_q.push_back(32'h33445566);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, b[i]);
      n_tests++;
      if (align_err !== 1'b0 || valid_out !== (i == 3)) begin
        n_fail++;
        $display("FAIL rmid_byte%0d: got ae=%b vo=%b, want 0 %b",
                 i, align_err, valid_out, (i == 3));
      end
    end
    n_tests++;
    if (data_out !== 32'h33445566) begin
      n_fail++;
      $display("FAIL rmid_word: got %08h, want 33445566", data_out);
    end
    idle(4);
  endtask

  task automatic test_boundary();
    logic [7:0] b [4];
    b = '{8'hC0, 8'hFF, 8'hEE, 8'h01};
    cycle(1'b1, 8'hA1);
    cycle(1'b1, 8'hA2);
    cycle(1'b1, 8'hA3);
    n_tests++;
    if (valid_out !== 1'b0 || align_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bnd_3bytes: got vo=%b ae=%b, want 0 0", valid_out, align_err);
    end
    cycle(1'b0, 8'h00);
    n_tests++;
    if (align_err !== 1'b1 || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL bnd_abort: got ae=%b vo=%b, want 1 0", align_err, valid_out);
    end
    cycle(1'b0, 8'h00);
    n_tests++;
    if (align_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bnd_pulse_width: got ae=%b, want 0", align_err);
    end
    exp_q.push_back(32'hC0FFEE01);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, b[i]);
      n_tests++;
      if (valid_out !== (i == 3) || align_err !== 1'b0) begin
        n_fail++;
        $display("FAIL bnd_clean%0d: got vo=%b ae=%b, want %b 0",
                 i, valid_out, align_err, (i == 3));
      end
    end
    n_tests++;
    if (data_out !== 32'hC0FFEE01) begin
      n_fail++;
      $display("FAIL bnd_word: got %08h, want C0FFEE01", data_out);
    end
    idle(4);
  endtask

  task automatic test_random_words();
    logic [31:0] word;
    logic [31:0] last;
    last = data_out;
    for (int w = 0; w < 12; w++) begin
      word = $urandom;
      // Consecutive equal words would be indistinguishable to the monitor.
      if (word == last) word = word ^ 32'h1;
      exp_q.push_back(word);
      for (int i = 0; i < 4; i++) begin
        cycle(1'b1, word[31-8*i -: 8]);
        n_tests++;
        if (align_err !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_ae w%0d b%0d: got %b, want 0", w, i, align_err);
        end
      end
      n_tests++;
      if (valid_out !== 1'b1 || data_out !== word) begin
        n_fail++;
        $display("FAIL rnd_word%0d: got vo=%b do=%08h, want 1 %08h",
                 w, valid_out, data_out, word);
      end
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 1; k <= 4; k++) begin
          cycle(1'b0, 8'($urandom_range(0, 255)));
          n_tests++;
          if (align_err !== 1'b0 || valid_out !== (k < 4)) begin
            n_fail++;
            $display("FAIL rnd_gap w%0d c%0d: got ae=%b vo=%b, want 0 %b",
                     w, k, align_err, valid_out, (k < 4));
          end
        end
      end
      last = word;
    end
    idle(4);
  endtask

  // -------------------------------------------------------------------------
  // Sequence and final report
  // -------------------------------------------------------------------------
  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;

    test_reset();
    test_single();
    test_back_to_back();
    test_aligned_gap();
    test_mid_gap();
    test_reset_mid();
    test_boundary();
    test_random_words();

    @(negedge clk_4f);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d words never produced, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
